// File: rtl/bioz_pkg.sv
// Purpose: shared types and default widths for the BioZ ADC capture path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bioz_pkg;

    localparam int BIOZ_ADC_BITS = 10;
    localparam int BIOZ_FSEL_W   = 4;

    // Capture FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_PUSH  = 2'd3
    } cap_state_t;

    // One tagged conversion result: frequency code in the upper bits
    typedef struct packed {
        logic [BIOZ_FSEL_W-1:0]   tag;
        logic [BIOZ_ADC_BITS-1:0] data;
    } bioz_sample_t;

endpackage

// File: rtl/bioz_sync_fifo.sv
// Purpose: small first-word-fall-through synchronous FIFO.
// Latency: a word pushed at edge n is visible at the head after edge n.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module bioz_sync_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_head_dat = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    always_comb begin
        w_do_pop  = i_pop & ~o_empty;
        w_do_push = i_push & (~o_full | w_do_pop);
    end

    // Storage, pointers and occupancy
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bioz_adc_capture.sv
// Purpose: deserialise SAR ADC frames, tag with Fsel, queue for readout (optional averaging: BIOZ_CAPTURE_AVG_EN).
// Latency: FIFO write at start edge + BIT_DELAY + ADC_BITS; Sample_Valid visible after that edge.
// Backpressure: valid/ready at the output; a full FIFO drops the new word and sets sticky Overflow.
module bioz_adc_capture
    import bioz_pkg::*;
#(
    parameter int ADC_BITS      = BIOZ_ADC_BITS,
    parameter int FSEL_W        = BIOZ_FSEL_W,
    parameter int ADC_CLK_CYCLE = 14,
    parameter int BIT_DELAY     = 1,
    parameter int FIFO_DEPTH    = 4,
    parameter int AVG_LOG2      = 2
) (
    input  logic                clk_ADC,
    input  logic                Reset,
    input  logic                ADC_En,
    input  logic                ADC_Start,
    input  logic                ADC_Dout,
    input  logic [FSEL_W-1:0]   Fsel,
    output logic [ADC_BITS-1:0] Sample,
    output logic [FSEL_W-1:0]   Sample_Fsel,
    output logic                Sample_Valid,
    input  logic                Sample_Ready,
    output logic                Overflow,
    output logic                Frame_Err,
    input  logic                Err_Clr
);

    localparam int DLY_W = (BIT_DELAY > 1) ? $clog2(BIT_DELAY) : 1;
    localparam int BIT_W = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;
    localparam int SMP_W = FSEL_W + ADC_BITS;

    // Frame timing must fit inside one conversion period
    if (BIT_DELAY < 1 || BIT_DELAY + ADC_BITS + 1 > ADC_CLK_CYCLE ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || AVG_LOG2 < 0) begin : g_bad_cfg
        $error("bioz_adc_capture: illegal parameter combination");
    end

    cap_state_t          r_state;
    cap_state_t          w_state_nxt;
    logic [DLY_W-1:0]    r_dly_cnt;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [ADC_BITS-1:0] r_shift;
    logic [FSEL_W-1:0]   r_fsel;
    logic                r_overflow;
    logic                r_frame_err;

    logic                w_start_frame;
    logic                w_frame_err_evt;
    logic                w_frame_done;
    logic                w_fifo_push;
    logic [SMP_W-1:0]    w_fifo_wdat;
    logic [SMP_W-1:0]    w_fifo_head;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_pop;
    logic                w_ovf_evt;

    // FSM state register
    always_ff @(posedge clk_ADC or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; a start in any busy state abandons the frame and restarts it
    always_comb begin
        w_state_nxt     = r_state;
        w_start_frame   = 1'b0;
        w_frame_err_evt = 1'b0;
        w_frame_done    = 1'b0;
        if (!ADC_En) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_start_frame = ADC_Start;
                end
                ST_WAIT: begin
                    if (ADC_Start) begin
                        w_start_frame   = 1'b1;
                        w_frame_err_evt = 1'b1;
                    end else if (r_dly_cnt <= DLY_W'(1)) begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ADC_Start) begin
                        w_start_frame   = 1'b1;
                        w_frame_err_evt = 1'b1;
                    end else if (r_bit_cnt == BIT_W'(ADC_BITS - 1)) begin
                        w_state_nxt = ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    if (ADC_Start) begin
                        w_start_frame   = 1'b1;
                        w_frame_err_evt = 1'b1;
                    end else begin
                        w_frame_done = 1'b1;
                        w_state_nxt  = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
            if (w_start_frame) begin
                w_state_nxt = (BIT_DELAY == 1) ? ST_SHIFT : ST_WAIT;
            end
        end
    end

    // Frame datapath: tag latch, delay count, MSB-first shift register
    always_ff @(posedge clk_ADC or posedge Reset) begin
        if (Reset) begin
            r_fsel    <= '0;
            r_dly_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_start_frame) begin
            r_fsel    <= Fsel;
            r_dly_cnt <= DLY_W'(BIT_DELAY - 1);
            r_bit_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_dly_cnt <= r_dly_cnt - 1'b1;
        end else if (r_state == ST_SHIFT) begin
            r_shift   <= {r_shift[ADC_BITS-2:0], ADC_Dout};
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

`ifdef BIOZ_CAPTURE_AVG_EN
    localparam int ACC_W = ADC_BITS + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;

    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_avg_cnt;
    logic [FSEL_W-1:0] r_avg_tag;
    logic              w_avg_cont;
    logic [ACC_W-1:0]  w_acc_sum;
    logic [CNT_W-1:0]  w_avg_cnt_nxt;
    logic              w_avg_full;

    // A tag change restarts the run with the current word instead of mixing frequencies
    always_comb begin
        w_avg_cont    = (r_avg_cnt != '0) && (r_avg_tag == r_fsel);
        w_acc_sum     = (w_avg_cont ? r_acc : '0) + ACC_W'(r_shift);
        w_avg_cnt_nxt = (w_avg_cont ? r_avg_cnt : '0) + 1'b1;
        w_avg_full    = (w_avg_cnt_nxt == CNT_W'(1 << AVG_LOG2));
        w_fifo_push   = w_frame_done & w_avg_full;
        w_fifo_wdat   = {r_fsel, w_acc_sum[AVG_LOG2 +: ADC_BITS]};
    end

    // Accumulator; cleared after each averaged push or when capture is disabled
    always_ff @(posedge clk_ADC or posedge Reset) begin
        if (Reset) begin
            r_acc     <= '0;
            r_avg_cnt <= '0;
            r_avg_tag <= '0;
        end else if (!ADC_En) begin
            r_acc     <= '0;
            r_avg_cnt <= '0;
        end else if (w_frame_done) begin
            r_avg_tag <= r_fsel;
            if (w_avg_full) begin
                r_acc     <= '0;
                r_avg_cnt <= '0;
            end else begin
                r_acc     <= w_acc_sum;
                r_avg_cnt <= w_avg_cnt_nxt;
            end
        end
    end
`else
    // Every completed frame goes straight to the FIFO
    always_comb begin
        w_fifo_push = w_frame_done;
        w_fifo_wdat = {r_fsel, r_shift};
    end
`endif

    assign w_pop     = ~w_fifo_empty & Sample_Ready;
    assign w_ovf_evt = w_fifo_push & w_fifo_full & ~w_pop;

    bioz_sync_fifo #(
        .WIDTH (SMP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (clk_ADC),
        .i_rst      (Reset),
        .i_push     (w_fifo_push),
        .i_push_dat (w_fifo_wdat),
        .i_pop      (w_pop),
        .o_head_dat (w_fifo_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    // Sticky error flags; a new event wins over a same-cycle clear
    always_ff @(posedge clk_ADC or posedge Reset) begin
        if (Reset) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (Err_Clr) begin
                r_overflow <= 1'b0;
            end
            if (w_frame_err_evt) begin
                r_frame_err <= 1'b1;
            end else if (Err_Clr) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign Sample       = w_fifo_head[ADC_BITS-1:0];
    assign Sample_Fsel  = w_fifo_head[SMP_W-1:ADC_BITS];
    assign Sample_Valid = ~w_fifo_empty;
    assign Overflow     = r_overflow;
    assign Frame_Err    = r_frame_err;

endmodule

// File: tb/tb_bioz_adc_capture.sv
// Purpose: self-checking bench for bioz_adc_capture (default build; averaging section with BIOZ_CAPTURE_AVG_EN).
// Latency: expected words queued at stimulus time, compared when the DUT hands them out.
// Backpressure: Sample_Ready is driven by the test sequences.
module tb_bioz_adc_capture;
    import bioz_pkg::*;

    logic       clk_ADC = 1'b0;
    logic       Reset;
    logic       ADC_En;
    logic       ADC_Start;
    logic       ADC_Dout;
    logic [3:0] Fsel;
    logic [9:0] Sample;
    logic [3:0] Sample_Fsel;
    logic       Sample_Valid;
    logic       Sample_Ready;
    logic       Overflow;
    logic       Frame_Err;
    logic       Err_Clr;

    int n_chk  = 0;
    int n_fail = 0;
    bioz_sample_t exp_q[$];

    typedef struct {
        logic [3:0] fsel;
        logic [9:0] bits;
        logic [9:0] exp_data;
        logic [3:0] exp_tag;
    } vec_t;
    vec_t vecs[5];

    bioz_adc_capture dut (
        .clk_ADC      (clk_ADC),
        .Reset        (Reset),
        .ADC_En       (ADC_En),
        .ADC_Start    (ADC_Start),
        .ADC_Dout     (ADC_Dout),
        .Fsel         (Fsel),
        .Sample       (Sample),
        .Sample_Fsel  (Sample_Fsel),
        .Sample_Valid (Sample_Valid),
        .Sample_Ready (Sample_Ready),
        .Overflow     (Overflow),
        .Frame_Err    (Frame_Err),
        .Err_Clr      (Err_Clr)
    );

    always #5 clk_ADC = ~clk_ADC;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ADC);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] tag, input logic [9:0] data);
        bioz_sample_t s;
        s.tag  = tag;
        s.data = data;
        exp_q.push_back(s);
    endtask

    // One frame: start sampled at the first edge, bits MSB first on the next ten edges,
    // Fsel scrambled after the start to prove the tag is latched. rdy_at pulses
    // Sample_Ready for the edge with that index (11 = push edge), -1 for none.
    task automatic run_frame(input logic [3:0] fs, input logic [9:0] bits, input int rdy_at);
        ADC_Start = 1'b1;
        Fsel      = fs;
        tick();
        ADC_Start = 1'b0;
        Fsel      = ~fs;
        for (int i = 9; i >= 0; i--) begin
            ADC_Dout = bits[i];
            tick();
        end
        ADC_Dout = 1'b0;
        for (int i = 11; i < 15; i++) begin
            if (i == rdy_at) Sample_Ready = 1'b1;
            tick();
            if (i == rdy_at) Sample_Ready = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        Sample_Ready = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        tick();
        chk({name, "_queue_left"}, exp_q.size(), 0);
        chk({name, "_valid_after"}, Sample_Valid, 1'b0);
    endtask

    // Scoreboard: every handshake must match the oldest expected word
    always @(negedge clk_ADC) begin
        if (!Reset && Sample_Valid && Sample_Ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h tag %0h, expected none", Sample, Sample_Fsel);
            end else begin
                bioz_sample_t e;
                e = exp_q.pop_front();
                chk("sample_data", Sample, e.data);
                chk("sample_tag", Sample_Fsel, e.tag);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{fsel: 4'hA, bits: 10'b1011001110, exp_data: 10'h2CE, exp_tag: 4'hA};
        vecs[1] = '{fsel: 4'h3, bits: 10'b0000000001, exp_data: 10'h001, exp_tag: 4'h3};
        vecs[2] = '{fsel: 4'hF, bits: 10'b1000000000, exp_data: 10'h200, exp_tag: 4'hF};
        vecs[3] = '{fsel: 4'h0, bits: 10'b1111111111, exp_data: 10'h3FF, exp_tag: 4'h0};
        vecs[4] = '{fsel: 4'h5, bits: 10'b0101010101, exp_data: 10'h155, exp_tag: 4'h5};

        Reset = 1'b1; ADC_En = 1'b1; ADC_Start = 1'b0; ADC_Dout = 1'b0;
        Fsel = 4'h0; Sample_Ready = 1'b0; Err_Clr = 1'b0;
        #12;
        chk("rst_sample", Sample, 10'h0);
        chk("rst_fsel", Sample_Fsel, 4'h0);
        chk("rst_valid", Sample_Valid, 1'b0);
        chk("rst_overflow", Overflow, 1'b0);
        chk("rst_frame_err", Frame_Err, 1'b0);
        tick();
        Reset = 1'b0;
        tick();
        tick();

`ifdef BIOZ_CAPTURE_AVG_EN
        begin
            logic [9:0] d_a[4];
            logic [9:0] d_c[4];
            d_a[0] = 10'd100; d_a[1] = 10'd101; d_a[2] = 10'd102; d_a[3] = 10'd104;
            d_c[0] = 10'd200; d_c[1] = 10'd201; d_c[2] = 10'd202; d_c[3] = 10'd203;
            Sample_Ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (i == 3) push_exp(4'h2, 10'd101);
                run_frame(4'h2, d_a[i], -1);
            end
            run_frame(4'h3, 10'd8, -1);
            run_frame(4'h3, 10'd9, -1);
            for (int i = 0; i < 4; i++) begin
                if (i == 3) push_exp(4'h7, 10'd201);
                run_frame(4'h7, d_c[i], -1);
            end
            drain("avg");
        end
`else
        // Single frame with exact write-edge timing, Ready held low
        ADC_Start = 1'b1; Fsel = 4'hA;
        tick();
        ADC_Start = 1'b0; Fsel = 4'h5;
        for (int i = 9; i >= 0; i--) begin
            ADC_Dout = vecs[0].bits[i];
            tick();
        end
        chk("single_valid_before_write", Sample_Valid, 1'b0);
        tick();
        chk("single_valid_after_write", Sample_Valid, 1'b1);
        chk("single_data", Sample, 10'h2CE);
        chk("single_tag", Sample_Fsel, 4'hA);
        tick();
        chk("single_hold_data", Sample, 10'h2CE);
        push_exp(4'hA, 10'h2CE);
        drain("single");

        // Table of frames with downstream always ready
        Sample_Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_exp(vecs[i].exp_tag, vecs[i].exp_data);
            run_frame(vecs[i].fsel, vecs[i].bits, -1);
        end
        drain("table");
        chk("table_overflow", Overflow, 1'b0);
        chk("table_frame_err", Frame_Err, 1'b0);

        // Back-pressure: four fit, fifth dropped
        Sample_Ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) push_exp(4'(i + 1), 10'(i * 93 + 5));
            run_frame(4'(i + 1), 10'(i * 93 + 5), -1);
            if (i == 3) chk("bp_overflow_before_drop", Overflow, 1'b0);
        end
        chk("bp_overflow_set", Overflow, 1'b1);
        Err_Clr = 1'b1;
        tick();
        Err_Clr = 1'b0;
        chk("bp_overflow_clear", Overflow, 1'b0);
        // Full FIFO with a pop on the push edge accepts the word without overflow
        push_exp(4'h6, 10'h1A5);
        run_frame(4'h6, 10'h1A5, 11);
        chk("full_push_pop_overflow", Overflow, 1'b0);
        drain("bp");

        // Early restart five edges into a frame
        Sample_Ready = 1'b1;
        ADC_Start = 1'b1; Fsel = 4'h1;
        tick();
        ADC_Start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ADC_Dout = 1'b1;
            tick();
        end
        push_exp(4'hC, 10'h0B7);
        run_frame(4'hC, 10'h0B7, -1);
        chk("restart_frame_err", Frame_Err, 1'b1);
        drain("restart");

        // Clear, then a new error in the same cycle as a clear must stick
        Err_Clr = 1'b1;
        tick();
        Err_Clr = 1'b0;
        chk("frame_err_clear", Frame_Err, 1'b0);
        ADC_Start = 1'b1; Fsel = 4'h2;
        tick();
        ADC_Start = 1'b0;
        tick();
        tick();
        ADC_Start = 1'b1; Err_Clr = 1'b1;
        tick();
        ADC_Start = 1'b0; Err_Clr = 1'b0;
        chk("frame_err_priority", Frame_Err, 1'b1);
        Err_Clr = 1'b1;
        tick();
        Err_Clr = 1'b0;
        chk("frame_err_clear2", Frame_Err, 1'b0);

        // Abort mid-SHIFT by dropping ADC_En: nothing pushed, no flags
        tick();
        tick();
        ADC_En = 1'b0;
        tick();
        ADC_En = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("abort_valid", Sample_Valid, 1'b0);
        chk("abort_frame_err", Frame_Err, 1'b0);
        chk("abort_overflow", Overflow, 1'b0);
        push_exp(4'h9, 10'h0F3);
        run_frame(4'h9, 10'h0F3, -1);
        drain("abort");

        // Asynchronous reset mid-frame with two words queued and Frame_Err set
        Sample_Ready = 1'b0;
        run_frame(4'h4, 10'h111, -1);
        run_frame(4'h8, 10'h222, -1);
        chk("pre_reset_valid", Sample_Valid, 1'b1);
        ADC_Start = 1'b1; Fsel = 4'h3;
        tick();
        ADC_Start = 1'b0;
        tick();
        ADC_Start = 1'b1;
        tick();
        ADC_Start = 1'b0;
        chk("pre_reset_frame_err", Frame_Err, 1'b1);
        tick();
        Reset = 1'b1;
        #1;
        chk("mid_reset_sample", Sample, 10'h0);
        chk("mid_reset_fsel", Sample_Fsel, 4'h0);
        chk("mid_reset_valid", Sample_Valid, 1'b0);
        chk("mid_reset_overflow", Overflow, 1'b0);
        chk("mid_reset_frame_err", Frame_Err, 1'b0);
        tick();
        Reset = 1'b0;
        tick();
        push_exp(4'hE, 10'h3A1);
        run_frame(4'hE, 10'h3A1, -1);
        drain("post_reset");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
